// File: rtl/seg_display_manager.sv
// seg_display_manager
// AHB-Lite slave driving a multiplexed 4-digit common-cathode seven-segment
// display. Digit, DP and blank data are written into a shadow set and copied
// to the active set only at the end of a full scan frame, so a display update
// never shows half old and half new digits.

module seg_display_manager #(
   parameter int SCAN_DIV = 32
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   input  logic        HWRITE,
   input  logic        HREADY,
   input  logic        HSEL,
   input  logic [2:0]  HSIZE,
   input  logic [1:0]  HTRANS,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic [3:0]  nDigit,
   output logic [7:0]  Seg
);

   localparam int            PW      = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] P_NIGHT = PW'(SCAN_DIV / 4);

   // Word index of each register (HADDR[4:2])
   localparam logic [2:0] REG_DIGITS = 3'd0;
   localparam logic [2:0] REG_DP     = 3'd1;
   localparam logic [2:0] REG_BLANK  = 3'd2;
   localparam logic [2:0] REG_CTRL   = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;
   localparam logic [2:0] REG_NONE   = 3'd7;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0:    hex_to_seg = 7'h3F;
         4'h1:    hex_to_seg = 7'h06;
         4'h2:    hex_to_seg = 7'h5B;
         4'h3:    hex_to_seg = 7'h4F;
         4'h4:    hex_to_seg = 7'h66;
         4'h5:    hex_to_seg = 7'h6D;
         4'h6:    hex_to_seg = 7'h7D;
         4'h7:    hex_to_seg = 7'h07;
         4'h8:    hex_to_seg = 7'h7F;
         4'h9:    hex_to_seg = 7'h6F;
         4'hA:    hex_to_seg = 7'h77;
         4'hB:    hex_to_seg = 7'h7C;
         4'hC:    hex_to_seg = 7'h39;
         4'hD:    hex_to_seg = 7'h5E;
         4'hE:    hex_to_seg = 7'h79;
         default: hex_to_seg = 7'h71;
      endcase
   endfunction

   // Bus pipeline
   logic        access;
   logic        write_q;
   logic [2:0]  addr_q;

   // Shadow set, control and status
   logic [15:0] digits_sh;
   logic [3:0]  dp_sh;
   logic [3:0]  blank_sh;
   logic [1:0]  ctrl_q;
   logic        pending_q;

   // Active set, the only data the display ever sees
   logic [15:0] digits_act;
   logic [3:0]  dp_act;
   logic [3:0]  blank_act;

   // Scan position
   logic [PW-1:0] p_q;
   logic [1:0]    d_q;

   logic        en;
   logic        night;
   logic        shadow_wr;
   logic        commit;
   logic        lit;
   logic [3:0]  cur_nib;
   logic [3:0]  ndigit_d;
   logic [7:0]  seg_d;

   assign en        = ctrl_q[0];
   assign night     = ctrl_q[1];
   assign access    = HSEL & HREADY & (HTRANS != 2'b00);
   assign shadow_wr = write_q & (addr_q <= REG_BLANK);
   assign commit    = en & (p_q == P_LAST) & (d_q == 2'd3) & pending_q;
   assign HREADYOUT = 1'b1;

   // Width and alignment bits the block does not decode
   logic unused_bits;
   assign unused_bits = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA[31:16]};

   // Address phase: remember what the following data phase belongs to
   always_ff @(posedge HCLK) begin
      // NOTE: reset is sampled synchronously here, and every clocked register
      // uses <= so all of them see the pre-edge values of each other.
      if (HRESET) begin
         write_q <= 1'b0;
         addr_q  <= REG_NONE;
      end else if (access) begin
         write_q <= HWRITE;
         addr_q  <= HADDR[4:2];
      end else begin
         write_q <= 1'b0;
         addr_q  <= REG_NONE;
      end
   end

   // Data phase writes, frame-boundary commit and the pending flag
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         digits_sh  <= '0;
         dp_sh      <= '0;
         blank_sh   <= '0;
         ctrl_q     <= '0;
         pending_q  <= 1'b0;
         digits_act <= '0;
         dp_act     <= '0;
         blank_act  <= '0;
      end else begin
         if (write_q) begin
            case (addr_q)
               REG_DIGITS: digits_sh <= HWDATA[15:0];
               REG_DP:     dp_sh     <= HWDATA[3:0];
               REG_BLANK:  blank_sh  <= HWDATA[3:0];
               REG_CTRL:   ctrl_q    <= HWDATA[1:0];
               default:    ;
            endcase
         end
         // A write landing on the commit edge still leaves its data pending
         if (commit) begin
            digits_act <= digits_sh;
            dp_act     <= dp_sh;
            blank_act  <= blank_sh;
         end
         if (shadow_wr)
            pending_q <= 1'b1;
         else if (commit)
            pending_q <= 1'b0;
      end
   end

   // Prescaler and digit index, parked at 0 while disabled
   always_ff @(posedge HCLK) begin
      if (HRESET || !en) begin
         p_q <= '0;
         d_q <= '0;
      end else if (p_q == P_LAST) begin
         p_q <= '0;
         d_q <= d_q + 2'd1;
      end else begin
         p_q <= p_q + PW'(1);
      end
   end

   // Next display drive from the current scan position and active set
   always_comb begin
      // NOTE: defaults first so no path through this block infers a latch.
      ndigit_d = 4'hF;
      seg_d    = 8'h00;
      cur_nib  = digits_act[{d_q, 2'b00} +: 4];
      lit      = en & ~blank_act[d_q] & (~night | (p_q < P_NIGHT));
      if (lit) begin
         ndigit_d = ~(4'b0001 << d_q);
         seg_d    = {dp_act[d_q], hex_to_seg(cur_nib)};
      end
   end

   // Registered display outputs, one cycle behind the scan position
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         nDigit <= 4'hF;
         Seg    <= 8'h00;
      end else begin
         nDigit <= ndigit_d;
         Seg    <= seg_d;
      end
   end

   // Read mux driven by the registered data-phase address
   always_comb begin
      HRDATA = '0;
      case (addr_q)
         REG_DIGITS: HRDATA[15:0] = digits_sh;
         REG_DP:     HRDATA[3:0]  = dp_sh;
         REG_BLANK:  HRDATA[3:0]  = blank_sh;
         REG_CTRL:   HRDATA[1:0]  = ctrl_q;
         REG_STATUS: HRDATA[0]    = pending_q;
         default:    ;
      endcase
   end

endmodule

// File: doc/seg_display_manager.md
# seg_display_manager

AHB-Lite write-side peripheral for the cycle computer: the processor writes four hex digits, decimal points, blanking and control into bus registers, and the block drives a multiplexed 4-digit common-cathode seven-segment display. Digit data is double-buffered and committed only at a frame boundary, so updates never tear. It sits on the same AHB-Lite bus as the input peripherals, zero wait state.

## Interface
Parameters:
- SCAN_DIV, 32: HCLK cycles each digit is selected. Legal range 4..1024, multiple of 4.

Ports:
- HCLK  input  1  bus and system clock.
- HRESET  input  1  reset, synchronous, active-high.
- HADDR  input  32  only [4:2] decoded.
- HWDATA  input  32  write data, data phase.
- HWRITE  input  1  1 = write.
- HREADY  input  1  bus ready.
- HSEL  input  1  slave select.
- HSIZE  input  3  ignored; all accesses are treated as word accesses.
- HTRANS  input  2  2'b00 = IDLE, no access; any other value = access.
- HRDATA  output  32  read data, data phase.
- HREADYOUT  output  1  tied 1.
- nDigit  output  4  digit enables, active-low; bit i = digit i, digit 0 = rightmost.
- Seg  output  8  segments, active-high; [6:0] = g..a, [7] = DP.

## Operation
- Register map (word offsets):
  - 0x00 DIGITS: shadow, [15:0], nibble i = digit i.
  - 0x04 DP: shadow, [3:0].
  - 0x08 BLANK: shadow, [3:0].
  - 0x0C CTRL: [0] EN, [1] NIGHT; not shadowed.
  - 0x10 STATUS: read-only, [0] PENDING.
  - Unused register bits read 0. Offsets 0x14–0x1C read 0; writes to them are ignored.
- Address phase:
  - An access is HSEL & HREADY & (HTRANS != 2'b00).
  - On an access, register HWRITE and HADDR[4:2].
  - Otherwise the registered write flag is cleared and the registered address is set to 7.
- Write, data phase: HWDATA is stored at the clock edge that ends the data phase.
  - A write to DIGITS, DP or BLANK sets PENDING.
  - A write to STATUS is ignored.
- Read: HRDATA is combinational from the registered address; it returns shadow values, CTRL, or STATUS.
- Active set: ACT_DIGITS, ACT_DP, ACT_BLANK. Only these drive the display.
- Scan:
  - Prescaler P counts 0..SCAN_DIV-1. Digit index D (2 bits) advances 0→1→2→3→0 when P = SCAN_DIV-1.
  - With EN=0, P and D are held at 0.
- Commit: at the edge where EN=1, P=SCAN_DIV-1, D=3 and PENDING=1:
  - active set ← shadow set;
  - PENDING ← 0.
- Hex decode, g..a:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Drive, computed from the current cycle and registered into the outputs:
  - Lit = EN & !ACT_BLANK[D] & (!NIGHT | P < SCAN_DIV/4).
  - If Lit: nDigit = ~(1<<D) and Seg = {ACT_DP[D], decode(ACT_DIGITS[4D+3:4D])}.
  - Otherwise: nDigit = 4'hF and Seg = 8'h00.
  - Only one nDigit bit may ever be low.

## Timing
- Reset:
  - All registers, P, D and PENDING are 0. The registered address is 7.
  - nDigit = 4'hF, Seg = 8'h00, HRDATA = 0, HREADYOUT = 1.
  - Reset during a bus transfer discards it.
- Output latency: Seg/nDigit reflect the P/D/active values of the previous cycle, i.e. one cycle.
- CTRL write:
  - Affects the outputs at the edge after the data-phase edge.
  - EN 1→0: the next edge resets P and D to 0; outputs blank one cycle later.
- Read after write to the same register: returns the new value; no wait state.
- Simultaneous shadow write and commit at the same edge:
  - The active set takes the old shadow.
  - The shadow takes HWDATA.
  - PENDING stays 1.
- Commit latency: first commit edge after the write, up to 4·SCAN_DIV cycles.
- Writes while EN=0 stay pending until a full frame completes after EN=1.
- Frame period: 4·SCAN_DIV cycles. NIGHT duty: SCAN_DIV/4 lit cycles per digit slot.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset: assert HRESET for 2 edges.
  - nDigit=F, Seg=00, and all reads return 0.
  - Deassert and leave EN=0: outputs stay blank indefinitely.
- Basic scan: write DIGITS=0x1234, then CTRL=1.
  - After commit, each 4-cycle slot shows digit0 Seg=66, digit1 Seg=4F, digit2 Seg=5B, digit3 Seg=06, with nDigit=E, D, B, 7 respectively.
  - PENDING reads 1 before the commit and 0 after it.
- Tear-free update: write DIGITS=0x8888 while D=1.
  - Digits 2 and 3 of the current frame still show the old values.
  - The new values appear from the next digit0 slot.
- Commit collision: write DIGITS=0xABCD with its data phase on the commit edge.
  - The active set takes the previous shadow.
  - Readback is 0xABCD and PENDING=1.
  - The next frame commits 0xABCD.
- Blank, DP and night: BLANK=0x2, DP=0x1, CTRL=3.
  - Digit1 slot is blank.
  - Digit0 shows Seg[7]=1.
  - Each digit is lit only at P=0, i.e. 1 cycle in 4.
- Bus corner cases:
  - HTRANS=IDLE with HSEL=1 and HWRITE=1: no register changes.
  - Read 0x14: returns 0.
  - Write to STATUS: ignored.
  - HREADYOUT stays 1 throughout.
